mem_arbiter: RTL and testbench

- N-port memory arbiter between CPU-side requesters and a single Memory instance. Port 0 is instruction fetch, port 1 is data, further ports are spare masters.
- Each port gets a one-entry command buffer. The buffered commands are serialised onto the memory command/read handshake.
- Arbitration is round-robin or fixed priority, selected by parameter. This generalises the fixed two-port instruction-first interface to NUM_PORTS, configurable widths and selectable fairness.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side handshake bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_PORTS-1:0]            p_cmd_start;
    logic [NUM_PORTS-1:0]            p_cmd_write;
    logic [NUM_PORTS-1:0]            p_cmd_ready;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata;
    logic [NUM_PORTS*DATA_WIDTH-1:0] p_wmask;
    logic [NUM_PORTS*DATA_WIDTH-1:0] p_rdata;
    logic [NUM_PORTS-1:0]            p_rdata_valid;
    logic [NUM_PORTS-1:0]            p_wdone;
    logic                            mem_cmd_start;
    logic                            mem_cmd_write;
    logic                            mem_cmd_ready;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic [DATA_WIDTH-1:0]           mem_wmask;
    logic [DATA_WIDTH-1:0]           mem_rdata;
    logic                            mem_rdata_valid;

    modport master (
        input  p_cmd_start, p_cmd_write, p_addr, p_wdata, p_wmask,
        input  mem_cmd_ready, mem_rdata, mem_rdata_valid,
        output p_cmd_ready, p_rdata, p_rdata_valid, p_wdone,
        output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output p_cmd_start, p_cmd_write, p_addr, p_wdata, p_wmask,
        output mem_cmd_ready, mem_rdata, mem_rdata_valid,
        input  p_cmd_ready, p_rdata, p_rdata_valid, p_wdone,
        input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-entry command slot per port, serialised onto a single memory port
module mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.master bus
);
    localparam int GW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READ} state_t;

    state_t                               state_q, state_d;
    logic [NUM_PORTS-1:0]                 pending_q, pending_d, wr_q, wr_d;
    logic [NUM_PORTS-1:0]                 rvalid_q, rvalid_d, wdone_q, wdone_d;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d, wmask_q, wmask_d;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [GW-1:0]                        grant_q, grant_d, rr_q, rr_d;
    logic [GW-1:0]                        win_lo, win_hi, win, grant_nxt;
    logic [NUM_PORTS-1:0]                 ready;
    logic                                 hi_any, sel_wr, issue, done;
    logic [ADDR_WIDTH-1:0]                sel_addr;
    logic [DATA_WIDTH-1:0]                sel_wdata, sel_wmask;

    assign ready     = ~pending_q & {NUM_PORTS{~reset}};
    assign issue     = state_q == ISSUE;
    assign grant_nxt = grant_q == GW'(NUM_PORTS - 1) ? '0 : grant_q + 1'b1;
    assign done      = (issue && bus.mem_cmd_ready && sel_wr) ||
                       (state_q == WAIT_READ && bus.mem_rdata_valid);

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        win_lo = '0;
        win_hi = '0;
        hi_any = 1'b0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (pending_q[p]) win_lo = GW'(p);
            if (pending_q[p] && GW'(p) >= rr_q) begin
                win_hi = GW'(p);
                hi_any = 1'b1;
            end
        end
        win = (ARB_MODE == 0 && hi_any) ? win_hi : win_lo;
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (GW'(p) == grant_q) begin
                sel_wr    = wr_q[p];
                sel_addr  = addr_q[p];
                sel_wdata = wdata_q[p];
                sel_wmask = wmask_q[p];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        grant_d   = grant_q;
        rr_d      = done ? grant_nxt : rr_q;
        rvalid_d  = '0;
        wdone_d   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.p_cmd_start[p] && ready[p]) begin
                wr_d[p]      = bus.p_cmd_write[p];
                addr_d[p]    = bus.p_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_d[p]   = bus.p_wdata[p*DATA_WIDTH +: DATA_WIDTH];
                wmask_d[p]   = bus.p_wmask[p*DATA_WIDTH +: DATA_WIDTH];
                pending_d[p] = 1'b1;
            end
            if (done && GW'(p) == grant_q) begin
                pending_d[p] = 1'b0;
                wdone_d[p]   = issue;
                rvalid_d[p]  = !issue;
                rdata_d[p]   = issue ? rdata_q[p] : bus.mem_rdata;
            end
        end
        case (state_q)
            IDLE: if (|pending_q) begin
                grant_d = win;
                state_d = ISSUE;
            end
            ISSUE:     if (bus.mem_cmd_ready) state_d = sel_wr ? IDLE : WAIT_READ;
            WAIT_READ: if (bus.mem_rdata_valid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            wr_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
            rvalid_q  <= '0;
            wdone_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            rvalid_q  <= rvalid_d;
            wdone_q   <= wdone_d;
        end
    end

    assign bus.p_cmd_ready   = ready;
    assign bus.p_rdata       = rdata_q;
    assign bus.p_rdata_valid = rvalid_q;
    assign bus.p_wdone       = wdone_q;
    assign bus.mem_cmd_start = issue;
    assign bus.mem_cmd_write = issue && sel_wr;
    assign bus.mem_addr      = issue ? sel_addr : '0;
    assign bus.mem_wdata     = issue ? sel_wdata : '0;
    assign bus.mem_wmask     = issue ? sel_wmask : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks on four arbiter configurations sharing one clock and reset
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int acc_a = 0;
    int nlog_r = 0;
    int nlog_f = 0;
    logic en_r = 1'b0;
    logic iss_r = 1'b0;
    logic iss_f = 1'b0;
    logic [1:0] log_r [0:15];
    logic [1:0] log_f [0:15];

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
    mem_arbiter_if #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifr ();
    mem_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifp ();
    mem_arbiter_if #(.NUM_PORTS(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) ifs ();

    mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    mem_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut_r (.clk(clk), .reset(reset), .bus(ifr));
    mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1)) dut_f (.clk(clk), .reset(reset), .bus(ifp));
    mem_arbiter #(.NUM_PORTS(1), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0)) dut_s (.clk(clk), .reset(reset), .bus(ifs));

    // Round-robin and fixed-priority instances use an always-ready memory answering one cycle after issue.
    assign ifr.p_cmd_write     = 3'b000;
    assign ifr.p_addr          = {32'd2, 32'd1, 32'd0};
    assign ifr.p_wdata         = '0;
    assign ifr.p_wmask         = '0;
    assign ifr.mem_cmd_ready   = 1'b1;
    assign ifr.mem_rdata       = 32'hC0DE;
    assign ifr.mem_rdata_valid = iss_r;
    assign ifp.p_cmd_write     = 2'b00;
    assign ifp.p_addr          = {32'd1, 32'd0};
    assign ifp.p_wdata         = '0;
    assign ifp.p_wmask         = '0;
    assign ifp.mem_cmd_ready   = 1'b1;
    assign ifp.mem_rdata       = 32'hF00D;
    assign ifp.mem_rdata_valid = iss_f;

    always @(negedge clk) ifr.p_cmd_start = en_r ? ifr.p_cmd_ready : 3'b000;

    always @(posedge clk) begin
        iss_r <= ifr.mem_cmd_start && ifr.mem_cmd_ready;
        iss_f <= ifp.mem_cmd_start && ifp.mem_cmd_ready;
        if (ifa.mem_cmd_start && ifa.mem_cmd_ready) acc_a <= acc_a + 1;
        if (en_r && ifr.mem_cmd_start) begin
            if (nlog_r < 16) log_r[nlog_r] <= ifr.mem_addr[1:0];
            nlog_r <= nlog_r + 1;
        end
        if (ifp.mem_cmd_start) begin
            if (nlog_f < 16) log_f[nlog_f] <= ifp.mem_addr[1:0];
            nlog_f <= nlog_f + 1;
        end
    end

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++; if (ifa.p_cmd_ready !== 2'b00) begin miscompares++; $display("FAIL rst_ready: got %b want 00", ifa.p_cmd_ready); end
        vectors++; if (ifa.mem_cmd_start !== 1'b0 || ifa.mem_cmd_write !== 1'b0) begin miscompares++; $display("FAIL rst_cmd: got %b%b want 00", ifa.mem_cmd_start, ifa.mem_cmd_write); end
        vectors++; if (ifa.mem_addr !== 32'h0 || ifa.mem_wdata !== 32'h0 || ifa.mem_wmask !== 32'h0) begin miscompares++; $display("FAIL rst_bus: got %h %h %h want zeros", ifa.mem_addr, ifa.mem_wdata, ifa.mem_wmask); end
        vectors++; if (ifa.p_rdata !== 64'h0 || ifa.p_rdata_valid !== 2'b00 || ifa.p_wdone !== 2'b00) begin miscompares++; $display("FAIL rst_resp: got %h %b %b want zeros", ifa.p_rdata, ifa.p_rdata_valid, ifa.p_wdone); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (ifa.p_cmd_ready !== 2'b11) begin miscompares++; $display("FAIL rst_release_ready: got %b want 11", ifa.p_cmd_ready); end
    endtask

    task automatic test_single_read;
        @(negedge clk);
        ifa.p_addr[31:0] = 32'h10; ifa.p_cmd_write = 2'b00; ifa.p_cmd_start = 2'b01;
        @(negedge clk);
        ifa.p_cmd_start = 2'b00;
        vectors++; if (ifa.mem_cmd_start !== 1'b0 || ifa.p_cmd_ready !== 2'b10) begin miscompares++; $display("FAIL rd_t1: got start %b ready %b want 0 10", ifa.mem_cmd_start, ifa.p_cmd_ready); end
        @(negedge clk);
        vectors++; if (ifa.mem_cmd_start !== 1'b1 || ifa.mem_cmd_write !== 1'b0 || ifa.mem_addr !== 32'h10) begin miscompares++; $display("FAIL rd_issue: got %b %b %h want 1 0 00000010", ifa.mem_cmd_start, ifa.mem_cmd_write, ifa.mem_addr); end
        @(negedge clk);
        vectors++; if (ifa.mem_cmd_start !== 1'b0 || ifa.mem_addr !== 32'h0) begin miscompares++; $display("FAIL rd_wait: got %b %h want 0 0", ifa.mem_cmd_start, ifa.mem_addr); end
        @(negedge clk);
        ifa.mem_rdata = 32'hDEADBEEF; ifa.mem_rdata_valid = 1'b1;
        vectors++; if (ifa.p_rdata_valid !== 2'b00) begin miscompares++; $display("FAIL rd_early: got %b want 00", ifa.p_rdata_valid); end
        @(negedge clk);
        ifa.mem_rdata = 32'h0; ifa.mem_rdata_valid = 1'b0;
        vectors++; if (ifa.p_rdata_valid !== 2'b01 || ifa.p_rdata[31:0] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_done: got %b %h want 01 deadbeef", ifa.p_rdata_valid, ifa.p_rdata[31:0]); end
        vectors++; if (ifa.p_cmd_ready !== 2'b11) begin miscompares++; $display("FAIL rd_ready: got %b want 11", ifa.p_cmd_ready); end
        @(negedge clk);
        vectors++; if (ifa.p_rdata_valid !== 2'b00 || ifa.p_rdata[31:0] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_hold: got %b %h want 00 deadbeef", ifa.p_rdata_valid, ifa.p_rdata[31:0]); end
    endtask

    task automatic test_write;
        @(negedge clk);
        ifa.p_addr[63:32] = 32'h20; ifa.p_wdata[63:32] = 32'h12345678; ifa.p_wmask[63:32] = 32'hFFFFFFFF;
        ifa.p_cmd_write = 2'b10; ifa.p_cmd_start = 2'b10;
        @(negedge clk);
        ifa.p_cmd_start = 2'b00;
        @(negedge clk);
        vectors++; if (ifa.mem_cmd_start !== 1'b1 || ifa.mem_cmd_write !== 1'b1 || ifa.mem_addr !== 32'h20) begin miscompares++; $display("FAIL wr_issue: got %b %b %h want 1 1 00000020", ifa.mem_cmd_start, ifa.mem_cmd_write, ifa.mem_addr); end
        vectors++; if (ifa.mem_wdata !== 32'h12345678 || ifa.mem_wmask !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL wr_data: got %h %h want 12345678 ffffffff", ifa.mem_wdata, ifa.mem_wmask); end
        @(negedge clk);
        vectors++; if (ifa.p_wdone !== 2'b10 || ifa.p_rdata_valid !== 2'b00 || ifa.p_cmd_ready !== 2'b11) begin miscompares++; $display("FAIL wr_done: got %b %b %b want 10 00 11", ifa.p_wdone, ifa.p_rdata_valid, ifa.p_cmd_ready); end
        @(negedge clk);
        ifa.p_cmd_write = 2'b00;
        vectors++; if (ifa.p_wdone !== 2'b00) begin miscompares++; $display("FAIL wr_pulse: got %b want 00", ifa.p_wdone); end
    endtask

    task automatic test_stall;
        int n0;
        ifa.mem_cmd_ready = 1'b0;
        @(negedge clk);
        ifa.p_addr[31:0] = 32'h44; ifa.p_cmd_start = 2'b01;
        @(negedge clk);
        ifa.p_cmd_start = 2'b00;
        n0 = acc_a;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++; if (ifa.mem_cmd_start !== 1'b1 || ifa.mem_addr !== 32'h44) begin miscompares++; $display("FAIL stall_hold%0d: got %b %h want 1 00000044", k, ifa.mem_cmd_start, ifa.mem_addr); end
            ifa.mem_rdata_valid = (k == 1);
            if (k == 4) ifa.mem_cmd_ready = 1'b1;
        end
        @(negedge clk);
        vectors++; if (ifa.mem_cmd_start !== 1'b0 || acc_a - n0 !== 1) begin miscompares++; $display("FAIL stall_accept: got start %b accepts %0d want 0 1", ifa.mem_cmd_start, acc_a - n0); end
        vectors++; if (ifa.p_rdata_valid !== 2'b00) begin miscompares++; $display("FAIL stall_ignore_valid: got %b want 00", ifa.p_rdata_valid); end
        ifa.mem_rdata = 32'h55; ifa.mem_rdata_valid = 1'b1;
        @(negedge clk);
        ifa.mem_rdata_valid = 1'b0;
        vectors++; if (ifa.p_rdata_valid !== 2'b01 || ifa.p_rdata[31:0] !== 32'h55) begin miscompares++; $display("FAIL stall_done: got %b %h want 01 00000055", ifa.p_rdata_valid, ifa.p_rdata[31:0]); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        ifa.p_addr = {32'h200, 32'h100}; ifa.p_cmd_write = 2'b11; ifa.p_cmd_start = 2'b11;
        @(negedge clk);
        ifa.p_cmd_start = 2'b00;
        @(negedge clk);
        vectors++; if (ifa.mem_cmd_start !== 1'b1 || ifa.mem_addr !== 32'h200) begin miscompares++; $display("FAIL b2b_first: got %b %h want 1 00000200", ifa.mem_cmd_start, ifa.mem_addr); end
        @(negedge clk);
        vectors++; if (ifa.p_wdone !== 2'b10 || ifa.mem_cmd_start !== 1'b0) begin miscompares++; $display("FAIL b2b_done1: got %b %b want 10 0", ifa.p_wdone, ifa.mem_cmd_start); end
        @(negedge clk);
        vectors++; if (ifa.mem_cmd_start !== 1'b1 || ifa.mem_addr !== 32'h100) begin miscompares++; $display("FAIL b2b_second: got %b %h want 1 00000100", ifa.mem_cmd_start, ifa.mem_addr); end
        @(negedge clk);
        ifa.p_cmd_write = 2'b00;
        vectors++; if (ifa.p_wdone !== 2'b01) begin miscompares++; $display("FAIL b2b_done0: got %b want 01", ifa.p_wdone); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        ifa.p_addr[31:0] = 32'h30; ifa.p_cmd_start = 2'b01;
        @(negedge clk);
        ifa.p_cmd_start = 2'b00;
        @(negedge clk);
        vectors++; if (ifa.mem_cmd_start !== 1'b1 || ifa.mem_addr !== 32'h30) begin miscompares++; $display("FAIL rm_issue: got %b %h want 1 00000030", ifa.mem_cmd_start, ifa.mem_addr); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (ifa.p_cmd_ready !== 2'b00) begin miscompares++; $display("FAIL rm_ready_low: got %b want 00", ifa.p_cmd_ready); end
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (ifa.p_cmd_ready !== 2'b11) begin miscompares++; $display("FAIL rm_ready_high: got %b want 11", ifa.p_cmd_ready); end
        ifa.mem_rdata = 32'hBAD; ifa.mem_rdata_valid = 1'b1;
        @(negedge clk);
        ifa.mem_rdata_valid = 1'b0;
        vectors++; if (ifa.p_rdata_valid !== 2'b00 || ifa.p_rdata !== 64'h0 || ifa.mem_cmd_start !== 1'b0) begin miscompares++; $display("FAIL rm_late_valid: got %b %h %b want 00 0 0", ifa.p_rdata_valid, ifa.p_rdata, ifa.mem_cmd_start); end
        @(negedge clk);
        vectors++; if (ifa.p_rdata_valid !== 2'b00 || ifa.p_wdone !== 2'b00) begin miscompares++; $display("FAIL rm_no_pulse: got %b %b want 00 00", ifa.p_rdata_valid, ifa.p_wdone); end
    endtask

    task automatic test_round_robin;
        @(negedge clk);
        en_r = 1'b1;
        for (int i = 0; i < 300 && nlog_r < 6; i++) @(negedge clk);
        en_r = 1'b0;
        vectors++; if (nlog_r < 6) begin miscompares++; $display("FAIL rr_timeout: got %0d grants want 6", nlog_r); end
        for (int i = 0; i < 6; i++) begin
            vectors++; if (int'(log_r[i]) !== i % 3) begin miscompares++; $display("FAIL rr_order%0d: got %0d want %0d", i, log_r[i], i % 3); end
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_fixed_priority;
        @(negedge clk);
        ifp.p_cmd_start = 2'b01;
        @(negedge clk);
        ifp.p_cmd_start = 2'b00;
        for (int i = 0; i < 50 && nlog_f < 1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        ifp.p_cmd_start = 2'b11;
        @(negedge clk);
        ifp.p_cmd_start = 2'b00;
        for (int i = 0; i < 50 && nlog_f < 3; i++) @(negedge clk);
        vectors++; if (nlog_f < 3) begin miscompares++; $display("FAIL fp_timeout: got %0d grants want 3", nlog_f); end
        vectors++; if (log_f[0] !== 2'd0 || log_f[1] !== 2'd0 || log_f[2] !== 2'd1) begin miscompares++; $display("FAIL fp_order: got %0d %0d %0d want 0 0 1", log_f[0], log_f[1], log_f[2]); end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_port;
        @(negedge clk);
        ifs.p_addr = 32'h5; ifs.p_wdata = 32'hA5; ifs.p_wmask = 32'hFF; ifs.p_cmd_write = 1'b1; ifs.p_cmd_start = 1'b1;
        @(negedge clk);
        ifs.p_cmd_start = 1'b0;
        vectors++; if (ifs.p_cmd_ready !== 1'b0) begin miscompares++; $display("FAIL sp_busy: got %b want 0", ifs.p_cmd_ready); end
        @(negedge clk);
        vectors++; if (ifs.mem_cmd_start !== 1'b1 || ifs.mem_cmd_write !== 1'b1 || ifs.mem_addr !== 32'h5 || ifs.mem_wdata !== 32'hA5) begin miscompares++; $display("FAIL sp_wr_issue: got %b %b %h %h want 1 1 5 a5", ifs.mem_cmd_start, ifs.mem_cmd_write, ifs.mem_addr, ifs.mem_wdata); end
        @(negedge clk);
        vectors++; if (ifs.p_wdone !== 1'b1 || ifs.p_cmd_ready !== 1'b1) begin miscompares++; $display("FAIL sp_wr_done: got %b %b want 1 1", ifs.p_wdone, ifs.p_cmd_ready); end
        ifs.p_addr = 32'h6; ifs.p_cmd_write = 1'b0; ifs.p_cmd_start = 1'b1;
        @(negedge clk);
        ifs.p_cmd_start = 1'b0;
        @(negedge clk);
        vectors++; if (ifs.mem_cmd_start !== 1'b1 || ifs.mem_cmd_write !== 1'b0 || ifs.mem_addr !== 32'h6) begin miscompares++; $display("FAIL sp_rd_issue: got %b %b %h want 1 0 6", ifs.mem_cmd_start, ifs.mem_cmd_write, ifs.mem_addr); end
        @(negedge clk);
        ifs.mem_rdata = 32'h77; ifs.mem_rdata_valid = 1'b1;
        @(negedge clk);
        ifs.mem_rdata_valid = 1'b0;
        vectors++; if (ifs.p_rdata_valid !== 1'b1 || ifs.p_rdata !== 32'h77) begin miscompares++; $display("FAIL sp_rd_done: got %b %h want 1 77", ifs.p_rdata_valid, ifs.p_rdata); end
    endtask

    initial begin
        ifa.p_cmd_start = '0; ifa.p_cmd_write = '0; ifa.p_addr = '0; ifa.p_wdata = '0; ifa.p_wmask = '0;
        ifa.mem_cmd_ready = 1'b1; ifa.mem_rdata = '0; ifa.mem_rdata_valid = 1'b0;
        ifs.p_cmd_start = '0; ifs.p_cmd_write = '0; ifs.p_addr = '0; ifs.p_wdata = '0; ifs.p_wmask = '0;
        ifs.mem_cmd_ready = 1'b1; ifs.mem_rdata = '0; ifs.mem_rdata_valid = 1'b0;
        ifp.p_cmd_start = '0;
        test_reset();
        test_single_read();
        test_write();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_round_robin();
        test_fixed_priority();
        test_single_port();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
